// File: rtl/ajuste_pkg.sv
// Shared encodings for the adjust-button front-end: edit field codes and
// the auto-repeat state machine states.
package ajuste_pkg;

    localparam logic [1:0] EN_NONE = 2'd0;
    localparam logic [1:0] EN_MIN  = 2'd1;
    localparam logic [1:0] EN_HORA = 2'd2;
    localparam logic [1:0] EN_SEG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } rep_state_t;

    function automatic logic [1:0] en_next(input logic [1:0] en);
        case (en)
            EN_NONE: return EN_MIN;
            EN_MIN:  return EN_HORA;
            EN_HORA: return EN_SEG;
            EN_SEG:  return EN_NONE;
            default: return EN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ajuste_debounce.sv
// Two-flop synchronizer followed by a stable-level filter: the level flips
// only after the synchronized input disagrees with it for DB_CYC cycles in a row.
module ajuste_debounce #(
    parameter int unsigned DB_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);
    localparam int unsigned CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYC);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // synchronizer, disagreement counter and accepted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/ajuste_botones.sv
// Adjust-button front-end: debounced up/down/sel produce the edit field code
// and gated single-cycle increment/decrement pulses with auto-repeat.
module ajuste_botones
    import ajuste_pkg::*;
#(
    parameter int unsigned DB_CYC   = 100000,
    parameter int unsigned HOLD_CYC = 50000000,
    parameter int unsigned REP_CYC  = 10000000,
    parameter int unsigned IDLE_CYC = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic [1:0] EN,
    output logic       aumento,
    output logic       disminuye
);
    localparam int unsigned RPT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int unsigned RCW     = $clog2(RPT_MAX + 1);
    localparam int unsigned ICW     = $clog2(IDLE_CYC + 1);
    localparam logic [RCW-1:0] HOLD_M1  = RCW'(HOLD_CYC - 1);
    localparam logic [RCW-1:0] REP_M1   = RCW'(REP_CYC - 1);
    localparam logic [RCW-1:0] RCNT_MAX = RCW'(RPT_MAX);
    localparam logic [ICW-1:0] IDLE_M1  = ICW'(IDLE_CYC - 1);
    localparam logic [ICW-1:0] ICNT_MAX = ICW'(IDLE_CYC);

    logic           up_s, dn_s, sel_s;
    logic           up_prev_r, dn_prev_r, sel_prev_r;
    logic           up_rise_s, dn_rise_s, sel_rise_s;
    rep_state_t     state_r, state_s;
    logic           dir_r, dir_s;
    logic [RCW-1:0] rcnt_r, rcnt_s, rcnt_inc_s;
    logic           active_s, other_s;
    logic           pulse_up_s, pulse_dn_s;
    logic [1:0]     en_r;
    logic [ICW-1:0] icnt_r;
    logic           idle_clr_s, idle_exp_s;
    logic           aumento_r, disminuye_r;

    ajuste_debounce #(.DB_CYC(DB_CYC)) u_db_up  (.clk(clk), .rst(rst), .btn(btn_up),   .level(up_s));
    ajuste_debounce #(.DB_CYC(DB_CYC)) u_db_dn  (.clk(clk), .rst(rst), .btn(btn_down), .level(dn_s));
    ajuste_debounce #(.DB_CYC(DB_CYC)) u_db_sel (.clk(clk), .rst(rst), .btn(btn_sel),  .level(sel_s));

    assign up_rise_s  = up_s & ~up_prev_r;
    assign dn_rise_s  = dn_s & ~dn_prev_r;
    assign sel_rise_s = sel_s & ~sel_prev_r;
    // dir_r = 1 means the down button owns the repeat sequence
    assign active_s   = dir_r ? dn_s : up_s;
    assign other_s    = dir_r ? up_s : dn_s;
    assign rcnt_inc_s = (rcnt_r == RCNT_MAX) ? rcnt_r : rcnt_r + RCW'(1);

    // previous debounced levels for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_prev_r  <= 1'b0;
            dn_prev_r  <= 1'b0;
            sel_prev_r <= 1'b0;
        end else begin
            up_prev_r  <= up_s;
            dn_prev_r  <= dn_s;
            sel_prev_r <= sel_s;
        end
    end

    // repeat FSM state, direction and interval counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            rcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            dir_r   <= dir_s;
            rcnt_r  <= rcnt_s;
        end
    end

    // repeat FSM next state
    always_comb begin
        state_s = state_r;
        dir_s   = dir_r;
        rcnt_s  = rcnt_r;
        case (state_r)
            IDLE: begin
                if (up_rise_s && dn_rise_s) begin
                    state_s = LOCK;
                end else if (up_rise_s) begin
                    state_s = HOLD;
                    dir_s   = 1'b0;
                    rcnt_s  = '0;
                end else if (dn_rise_s) begin
                    state_s = HOLD;
                    dir_s   = 1'b1;
                    rcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD, REPEAT: begin
                if (other_s) begin
                    state_s = LOCK;
                end else if (!active_s) begin
                    state_s = IDLE;
                end else if (rcnt_r == ((state_r == HOLD) ? HOLD_M1 : REP_M1)) begin
                    state_s = REPEAT;
                    rcnt_s  = '0;
                end else begin
                    rcnt_s  = rcnt_inc_s;
                end
            end
            LOCK: begin
                if (!up_s && !dn_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCK;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // repeat FSM pulse requests, one direction at most
    always_comb begin
        pulse_up_s = 1'b0;
        pulse_dn_s = 1'b0;
        case (state_r)
            IDLE: begin
                pulse_up_s = up_rise_s & ~dn_rise_s;
                pulse_dn_s = dn_rise_s & ~up_rise_s;
            end
            HOLD, REPEAT: begin
                if (!other_s && active_s &&
                    rcnt_r == ((state_r == HOLD) ? HOLD_M1 : REP_M1)) begin
                    pulse_up_s = ~dir_r;
                    pulse_dn_s = dir_r;
                end else begin
                    pulse_up_s = 1'b0;
                    pulse_dn_s = 1'b0;
                end
            end
            default: begin
                pulse_up_s = 1'b0;
                pulse_dn_s = 1'b0;
            end
        endcase
    end

    // registered, field-gated pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aumento_r   <= 1'b0;
            disminuye_r <= 1'b0;
        end else begin
            aumento_r   <= pulse_up_s & (en_r != EN_NONE);
            disminuye_r <= pulse_dn_s & (en_r != EN_NONE);
        end
    end

    assign idle_clr_s = up_s | dn_s | sel_s | (en_r == EN_NONE);
    assign idle_exp_s = ~idle_clr_s & (icnt_r == IDLE_M1);

    // field select and inactivity timeout; timeout wins over a select edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r   <= EN_NONE;
            icnt_r <= '0;
        end else begin
            if (idle_clr_s) begin
                icnt_r <= '0;
            end else if (icnt_r != ICNT_MAX) begin
                icnt_r <= icnt_r + ICW'(1);
            end else begin
                icnt_r <= icnt_r;
            end
            if (idle_exp_s) begin
                en_r <= EN_NONE;
            end else if (sel_rise_s && !up_s && !dn_s) begin
                en_r <= en_next(en_r);
            end else begin
                en_r <= en_r;
            end
        end
    end

    assign EN        = en_r;
    assign aumento   = aumento_r;
    assign disminuye = disminuye_r;

endmodule

// File: tb/tb_ajuste_botones.sv
// Bench for ajuste_botones: directed test-plan scenarios plus random button
// activity, all checked cycle by cycle against a behavioural model.
module tb_ajuste_botones;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int IDLE = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_sel;
    logic [1:0] EN;
    logic       aumento, disminuye;

    int total = 0;
    int bad   = 0;

    // model state: index 0 up, 1 down, 2 sel
    int m_s1 [3];
    int m_s2 [3];
    int m_lvl [3];
    int m_old [3];
    int m_run [3];
    int m_en, m_idle, m_mode, m_dir, m_t, m_aum, m_dis;

    ajuste_botones #(
        .DB_CYC(DB), .HOLD_CYC(HOLD), .REP_CYC(REP), .IDLE_CYC(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .EN(EN), .aumento(aumento), .disminuye(disminuye)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_old[b] = 0; m_run[b] = 0;
        end
        m_en = 0; m_idle = 0; m_mode = 0; m_dir = 0; m_t = 0; m_aum = 0; m_dis = 0;
    endtask

    function automatic bit pulse_due(input int t);
        return (t == HOLD) || (t > HOLD && ((t - HOLD) % REP) == 0);
    endfunction

    // one clock edge of the reference behaviour, raw inputs as seen at that edge
    task automatic model_step(input bit u, input bit d, input bit s);
        int raw [3];
        int rise [3];
        int pu, pd, en_pre, any_lvl;
        raw[0] = u; raw[1] = d; raw[2] = s;
        pu = 0; pd = 0; en_pre = m_en;
        for (int b = 0; b < 3; b++) rise[b] = (m_lvl[b] == 1 && m_old[b] == 0) ? 1 : 0;
        any_lvl = m_lvl[0] | m_lvl[1] | m_lvl[2];
        if (m_mode == 0) begin
            if (rise[0] == 1 && rise[1] == 1) m_mode = 2;
            else if (rise[0] == 1) begin pu = 1; m_mode = 1; m_dir = 0; m_t = 0; end
            else if (rise[1] == 1) begin pd = 1; m_mode = 1; m_dir = 1; m_t = 0; end
        end else if (m_mode == 1) begin
            if (m_lvl[1 - m_dir] == 1) m_mode = 2;
            else if (m_lvl[m_dir] == 0) m_mode = 0;
            else begin
                m_t++;
                if (pulse_due(m_t)) begin
                    if (m_dir == 1) pd = 1; else pu = 1;
                end
            end
        end else begin
            if (m_lvl[0] == 0 && m_lvl[1] == 0) m_mode = 0;
        end
        if (m_en != 0 && any_lvl == 0) m_idle++; else m_idle = 0;
        if (m_idle == IDLE) begin
            m_en = 0; m_idle = 0;
        end else if (rise[2] == 1 && m_lvl[0] == 0 && m_lvl[1] == 0) begin
            m_en = (m_en + 1) % 4;
        end
        m_aum = (pu == 1 && en_pre != 0) ? 1 : 0;
        m_dis = (pd == 1 && en_pre != 0) ? 1 : 0;
        for (int b = 0; b < 3; b++) begin
            m_old[b] = m_lvl[b];
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin m_lvl[b] = m_s2[b]; m_run[b] = 0; end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    // drive one cycle from a falling edge and compare after the next rising edge
    task automatic cycle(input bit u, input bit d, input bit s);
        btn_up = u; btn_down = d; btn_sel = s;
        model_step(u, d, s);
        @(posedge clk);
        @(negedge clk);
        check("EN", {30'd0, EN}, m_en);
        check("aumento", {31'd0, aumento}, m_aum);
        check("disminuye", {31'd0, disminuye}, m_dis);
        check("exclusive", {31'd0, aumento & disminuye}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_EN", {30'd0, EN}, 32'd0);
        check("rst_aumento", {31'd0, aumento}, 32'd0);
        check("rst_disminuye", {31'd0, disminuye}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_walk [5];
        int prev, cnt, last_n;
        int rem [3];
        bit lv [3];
        exp_walk = '{1, 2, 3, 0, 1};
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        model_reset();
        #2;
        do_reset();

        // sel walk
        for (int i = 0; i < 5; i++) begin
            prev = (i == 0) ? 0 : exp_walk[i - 1];
            for (int n = 1; n <= 22; n++) begin
                cycle(1'b0, 1'b0, n <= 10);
                if (n == 6) check("sel_before", {30'd0, EN}, prev);
                if (n == 7) check("sel_walk", {30'd0, EN}, exp_walk[i]);
            end
        end

        // bounce rejection then a clean hold
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            cycle(((n / 3) % 2) == 0, 1'b0, 1'b0);
            if (aumento) cnt++;
        end
        check("bounce_quiet", cnt, 0);
        cnt = 0;
        for (int n = 1; n <= 27; n++) begin
            cycle(n <= 12, 1'b0, 1'b0);
            if (n == 6) check("bounce_early", {31'd0, aumento}, 0);
            if (n == 7) check("bounce_pulse", {31'd0, aumento}, 1);
            if (aumento) cnt++;
        end
        check("bounce_once", cnt, 1);

        // auto-repeat on down
        cnt = 0; last_n = 0;
        for (int n = 1; n <= 80; n++) begin
            cycle(1'b0, n <= 60, 1'b0);
            if (n == 7 || n == 27 || n == 32 || n == 37) check("rep_pulse", {31'd0, disminuye}, 1);
            if (disminuye) begin cnt++; last_n = n; end
        end
        check("rep_count", cnt, 9);
        check("rep_last", last_n, 62);

        // conflict lockout
        cnt = 0;
        for (int n = 1; n <= 70; n++) begin
            cycle(1'b1, n > 40, 1'b0);
            if (n == 37) check("lock_repeat", {31'd0, aumento}, 1);
            if (n >= 43 && aumento) cnt++;
        end
        for (int n = 1; n <= 40; n++) begin
            cycle(n <= 20, 1'b0, 1'b0);
            if (aumento) cnt++;
        end
        check("lock_quiet", cnt, 0);
        for (int n = 1; n <= 27; n++) begin
            cycle(n <= 12, 1'b0, 1'b0);
            if (n == 7) check("lock_fresh", {31'd0, aumento}, 1);
        end

        // select to hours, then inactivity timeout
        for (int n = 1; n <= 130; n++) begin
            cycle(1'b0, 1'b0, n <= 10);
            if (n == 7) check("to_sel", {30'd0, EN}, 2);
            if (n == 115) check("to_before", {30'd0, EN}, 2);
            if (n == 116) check("to_expire", {30'd0, EN}, 0);
        end

        // gating while no field is selected
        cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            cycle(n <= 25, 1'b0, 1'b0);
            if (aumento) cnt++;
        end
        check("gate_quiet", cnt, 0);

        // asynchronous reset in the middle of auto-repeat
        for (int n = 1; n <= 20; n++) cycle(1'b0, 1'b0, n <= 10);
        check("rst_prep_EN", {30'd0, EN}, 1);
        for (int n = 1; n <= 37; n++) cycle(1'b1, 1'b0, 1'b0);
        check("pre_rst_pulse", {31'd0, aumento}, 1);
        do_reset();
        cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (aumento) cnt++;
        end
        check("post_rst_gated", cnt, 0);
        for (int n = 1; n <= 15; n++) cycle(1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 20; n++) cycle(1'b0, 1'b0, n <= 10);
        for (int n = 1; n <= 25; n++) begin
            cycle(n <= 12, 1'b0, 1'b0);
            if (n == 7) check("post_rst_pulse", {31'd0, aumento}, 1);
        end

        // random button activity
        for (int b = 0; b < 3; b++) begin rem[b] = 0; lv[b] = 1'b0; end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lv[b] = ($urandom_range(0, 99) < ((b == 2) ? 25 : 40));
                    rem[b] = $urandom_range(1, 30);
                end else begin
                    rem[b]--;
                end
            end
            if (c == 1500) do_reset();
            cycle(lv[0], lv[1], lv[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
